perceptron_seq: RTL and testbench
=================================

Name: perceptron_seq

Overview:
Sequencer that drives one pipelined MAC unit to compute a full perceptron dot product. It holds the weight vector and firing threshold, and accepts a stream of input activations. It issues one x/w pair at a time to the MAC and feeds the running sum back on the MAC's previous_out. After the last element it presents the sum and a threshold-compare fire bit. It sits between the input stream and the MAC instance in the perceptron top level.

Parameters:
N_INPUTS, 4, elements per input vector (>=2)
X_W, 4, activation width
W_W, 4, weight width
ACC_W, 8, sum width (equals MAC product/out width)
MAC_LAT, 3, cycles from operands presented on mac_* to valid mac_out

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cfg_we  in  1  weight write strobe
cfg_addr  in  $clog2(N_INPUTS)  weight index
cfg_wdata  in  W_W  weight value
cfg_th_we  in  1  threshold write strobe
cfg_th  in  ACC_W  threshold value
in_valid  in  1  activation valid
in_ready  out  1  block can accept activation
in_x  in  X_W  activation
in_last  in  1  producer's end-of-vector marker
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_sum  out  ACC_W  dot product, modulo 2^ACC_W
out_fire  out  1  out_sum >= threshold (unsigned)
err_len  out  1  sticky: in_last disagreed with element count
mac_x  out  X_W  MAC operand x
mac_w  out  W_W  MAC operand w
mac_prev  out  ACC_W  MAC previous_out (running sum)
mac_out  in  ACC_W  MAC result

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state ACCEPT, idx 0, acc 0, all weights 0, threshold 0, wait counter 0.
- Reset values of outputs: out_valid 0, out_sum 0, out_fire 0, err_len 0, mac_x/mac_w 0, mac_prev 0.
- FSM ACCEPT: in_ready=1, and in_ready is 1 only in this state. On in_valid&in_ready at edge t:
  - mac_x<=in_x; mac_w<=weight[idx].
  - If in_last != (idx==N_INPUTS-1), set err_len (sticky until rst).
  - Go to WAIT.
- FSM WAIT: lasts exactly MAC_LAT cycles (t+1..t+MAC_LAT). mac_x, mac_w and mac_prev are held stable throughout. Then go to CAPTURE.
- FSM CAPTURE: one cycle (t+1+MAC_LAT). acc<=mac_out.
  - If idx==N_INPUTS-1: out_sum<=mac_out; out_fire<=(mac_out>=threshold); out_valid<=1; go to DONE.
  - Else: idx<=idx+1; go to ACCEPT.
- FSM DONE: out_valid=1, and out_sum/out_fire are held stable. On out_valid&out_ready: out_valid<=0, acc<=0, idx<=0; go to ACCEPT.
- mac_prev is driven from acc at all times. It is 0 for element 0 of every vector.
- Throughput: one element per MAC_LAT+2 cycles. Earliest next in_ready after an accept at t is cycle t+MAC_LAT+2.
- Arithmetic: the MAC wraps modulo 2^ACC_W and the controller does not saturate. The compare is unsigned.
- Vector length: fixed at N_INPUTS. in_last only affects err_len and never truncates or extends a vector.
- Config writes are allowed in any state and take effect at the edge.
  - A weight is sampled into mac_w at that element's accept, so later writes do not disturb an in-flight element.
  - Threshold is sampled at CAPTURE of the final element.
  - A write to the same address as the current accept in the same cycle: the accept uses the old value.
- in_valid while not in ACCEPT is ignored, since in_ready=0.
- out_ready while out_valid=0 is ignored.
- rst asserted in any state, including mid-WAIT, returns everything to reset values immediately. The MAC's own reset is sequenced by the top level.

Decomposition:
- Package perceptron_pkg holds:
  - the state enum (ACCEPT, WAIT, CAPTURE, DONE);
  - default constants for N_INPUTS, X_W, W_W, ACC_W, MAC_LAT.
- One sub-module, perceptron_weight_rf: N_INPUTS x W_W register file with async-reset, a single write port and a combinational read by idx.

Test Plan:
- N=4, weights {1,2,3,4}, threshold 10, x={1,1,1,1} with in_last on element 3 -> out_sum=10, out_fire=1, err_len=0.
- Same vector with threshold 11 -> out_sum=10, out_fire=0.
- Wrap check: weights all 15, x all 15 -> out_sum=900 mod 256=132.
- Timing, in_valid held high: accepts at cycles 0, 5, 10, 15 (MAC_LAT=3); out_valid rises at cycle 20; mac_prev is 0 during element 0.
- Backpressure: out_ready low 6 cycles -> out_valid, out_sum and out_fire stable, in_ready=0; result consumed on the first out_ready=1 cycle, in_ready=1 next cycle; the next vector's sum is unaffected by the prior acc.
- Robustness: in_last on element 1 -> err_len=1 and the sum still uses 4 elements. rst pulsed mid-WAIT of element 2 -> all outputs return to reset values; a following clean vector gives the correct sum with err_len=0.

Source files
------------

// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared defaults and sequencer state encoding for the perceptron block
package perceptron_pkg;

    localparam int N_INPUTS_DEF = 4;
    localparam int X_W_DEF      = 4;
    localparam int W_W_DEF      = 4;
    localparam int ACC_W_DEF    = 8;
    localparam int MAC_LAT_DEF  = 3;

    typedef enum logic [1:0] {
        ACCEPT  = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } seq_state_e;

endpackage

// File: rtl/perceptron_weight_rf.sv
// rtl/perceptron_weight_rf.sv - weight register file, one write port, combinational read
module perceptron_weight_rf
    import perceptron_pkg::*;
#(
    parameter int N_INPUTS = N_INPUTS_DEF,
    parameter int W_W      = W_W_DEF,
    localparam int AW      = $clog2(N_INPUTS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W_W-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W_W-1:0] rdata_o
);

    logic [W_W-1:0] mem_q [N_INPUTS];

    // Out-of-range addresses (non power-of-two depth) are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (int'(waddr_i) < N_INPUTS)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/perceptron_seq.sv
// rtl/perceptron_seq.sv - sequences one pipelined MAC across a vector and thresholds the dot product
module perceptron_seq
    import perceptron_pkg::*;
#(
    parameter int N_INPUTS = N_INPUTS_DEF,
    parameter int X_W      = X_W_DEF,
    parameter int W_W      = W_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int MAC_LAT  = MAC_LAT_DEF,
    localparam int IDX_W   = $clog2(N_INPUTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [W_W-1:0]   cfg_wdata,
    input  logic             cfg_th_we,
    input  logic [ACC_W-1:0] cfg_th,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [X_W-1:0]   in_x,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_fire,
    output logic             err_len,
    output logic [X_W-1:0]   mac_x,
    output logic [W_W-1:0]   mac_w,
    output logic [ACC_W-1:0] mac_prev,
    input  logic [ACC_W-1:0] mac_out
);

    localparam int CNT_W = $clog2(MAC_LAT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAC_LAT - 1);

    seq_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] th_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_sum_q;
    logic             out_fire_q;
    logic             err_len_q;
    logic [X_W-1:0]   mac_x_q;
    logic [W_W-1:0]   mac_w_q;

    logic [W_W-1:0]   weight_rd;
    logic             is_last_d;
    logic             fire_d;

    perceptron_weight_rf #(
        .N_INPUTS (N_INPUTS),
        .W_W      (W_W)
    ) u_weight_rf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (cfg_we),
        .waddr_i (cfg_addr),
        .wdata_i (cfg_wdata),
        .raddr_i (idx_q),
        .rdata_o (weight_rd)
    );

    assign is_last_d = (idx_q == LAST_IDX);
    assign fire_d    = (mac_out >= th_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            th_q <= '0;
        end else if (cfg_th_we) begin
            th_q <= cfg_th;
        end
    end

    // Reading the register file before the edge gives the accept the pre-write weight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCEPT;
            idx_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_fire_q  <= 1'b0;
            err_len_q   <= 1'b0;
            mac_x_q     <= '0;
            mac_w_q     <= '0;
        end else begin
            case (state_q)
                ACCEPT: begin
                    if (in_valid) begin
                        mac_x_q <= in_x;
                        mac_w_q <= weight_rd;
                        cnt_q   <= '0;
                        if (in_last != is_last_d) begin
                            err_len_q <= 1'b1;
                        end
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_q <= CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    acc_q <= mac_out;
                    if (is_last_d) begin
                        out_sum_q   <= mac_out;
                        out_fire_q  <= fire_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= ACCEPT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        idx_q       <= '0;
                        state_q     <= ACCEPT;
                    end
                end
                default: state_q <= ACCEPT;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCEPT);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_fire  = out_fire_q;
    assign err_len   = err_len_q;
    assign mac_x     = mac_x_q;
    assign mac_w     = mac_w_q;
    assign mac_prev  = acc_q;

endmodule

// File: tb/tb_perceptron_seq.sv
// tb/tb_perceptron_seq.sv - scoreboard bench for perceptron_seq with an external pipelined MAC
module tb_perceptron_seq;

    localparam int N   = 4;
    localparam int XW  = 4;
    localparam int WW  = 4;
    localparam int AW  = 8;
    localparam int LAT = 3;
    localparam int IW  = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic [WW-1:0] cfg_wdata;
    logic          cfg_th_we;
    logic [AW-1:0] cfg_th;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] in_x;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic          out_fire;
    logic          err_len;
    logic [XW-1:0] mac_x;
    logic [WW-1:0] mac_w;
    logic [AW-1:0] mac_prev;
    logic [AW-1:0] mac_out;

    always #5 clk = ~clk;

    perceptron_seq #(
        .N_INPUTS (N),
        .X_W      (XW),
        .W_W      (WW),
        .ACC_W    (AW),
        .MAC_LAT  (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_th_we (cfg_th_we),
        .cfg_th    (cfg_th),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_fire  (out_fire),
        .err_len   (err_len),
        .mac_x     (mac_x),
        .mac_w     (mac_w),
        .mac_prev  (mac_prev),
        .mac_out   (mac_out)
    );

    // External MAC: out = prev + x*w, LAT cycles after operands.
    logic [AW-1:0] pipe [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= AW'(mac_prev + AW'(mac_x) * AW'(mac_w));
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mac_out = pipe[LAT-1];

    typedef struct {
        int sum;
        bit fire;
    } exp_t;

    exp_t exp_q[$];
    int   w_m[N];
    int   th_m;
    bit   err_m;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rnd_bp = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            #1;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got sum %0d with no expected entry", out_sum);
                end else begin
                    e = exp_q.pop_front();
                    check("out_sum", int'(out_sum), e.sum);
                    check("out_fire", int'(out_fire), int'(e.fire));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic write_w(int a, int v);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = IW'(a); cfg_wdata = WW'(v);
        @(negedge clk);
        cfg_we = 1'b0;
        w_m[a] = v;
    endtask

    task automatic write_th(int v);
        @(negedge clk);
        cfg_th_we = 1'b1; cfg_th = AW'(v);
        @(negedge clk);
        cfg_th_we = 1'b0;
        th_m = v;
    endtask

    task automatic send_elem(int x, bit last, bit wr, int wa, int wv);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1; in_x = XW'(x); in_last = last;
        if (wr) begin
            cfg_we = 1'b1; cfg_addr = IW'(wa); cfg_wdata = WW'(wv);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic send_vector(int xs[N], int last_pos, int wa, int wv);
        exp_t e;
        int s = 0;
        for (int i = 0; i < N; i++) s += xs[i] * w_m[i];
        e.sum  = s % 256;
        e.fire = (e.sum >= th_m);
        exp_q.push_back(e);
        if (last_pos != N - 1) err_m = 1'b1;
        for (int i = 0; i < N; i++) send_elem(xs[i], (i == last_pos), (wa == i), wa, wv);
        if (wa >= 0) w_m[wa] = wv;
    endtask

    task automatic drain(string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check({name, "_drain_timeout"}, exp_q.size(), 0);
        @(negedge clk);
        check({name, "_err_len"}, int'(err_len), int'(err_m));
    endtask

    task automatic check_reset_outputs(string name);
        check({name, "_in_ready"}, int'(in_ready), 1);
        check({name, "_out_valid"}, int'(out_valid), 0);
        check({name, "_out_sum"}, int'(out_sum), 0);
        check({name, "_out_fire"}, int'(out_fire), 0);
        check({name, "_err_len"}, int'(err_len), 0);
        check({name, "_mac_x"}, int'(mac_x), 0);
        check({name, "_mac_w"}, int'(mac_w), 0);
        check({name, "_mac_prev"}, int'(mac_prev), 0);
    endtask

    task automatic reset_model();
        for (int i = 0; i < N; i++) w_m[i] = 0;
        th_m  = 0;
        err_m = 1'b0;
    endtask

    initial begin
        int acc_c[4];
        int ov_c;
        int nacc;
        bit got_ov;
        int xs[N];
        int n;

        rst = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        cfg_th_we = 1'b0; cfg_th = '0;
        in_valid = 1'b0; in_x = '0; in_last = 1'b0;
        out_ready = 1'b1;
        reset_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        for (int i = 0; i < N; i++) write_w(i, i + 1);
        write_th(10);
        send_vector('{1, 1, 1, 1}, N - 1, -1, 0);
        drain("basic_th10");

        write_th(11);
        send_vector('{1, 1, 1, 1}, N - 1, -1, 0);
        drain("basic_th11");

        for (int i = 0; i < N; i++) write_w(i, 15);
        write_th(200);
        send_vector('{15, 15, 15, 15}, N - 1, -1, 0);
        drain("wrap");

        // Streaming timing with in_valid held high.
        for (int i = 0; i < N; i++) write_w(i, i + 1);
        write_th(0);
        begin
            exp_t e;
            e.sum = 10; e.fire = 1'b1;
            exp_q.push_back(e);
        end
        nacc = 0; got_ov = 1'b0; ov_c = 0;
        for (int k = 0; k < 80 && !got_ov; k++) begin
            if (nacc == 4) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end else if (in_ready) begin
                in_valid = 1'b1; in_x = XW'(1); in_last = (nacc == 3);
                acc_c[nacc] = cyc;
                nacc++;
            end else if (nacc == 1) begin
                check("mac_prev_elem0", int'(mac_prev), 0);
            end
            if (out_valid) begin
                ov_c = cyc;
                got_ov = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check("timing_out_valid_seen", int'(got_ov), 1);
        check("timing_accept1", acc_c[1] - acc_c[0], 5);
        check("timing_accept2", acc_c[2] - acc_c[0], 10);
        check("timing_accept3", acc_c[3] - acc_c[0], 15);
        check("timing_out_valid", ov_c - acc_c[0], 20);
        drain("timing");

        // Backpressure: 3*1+5*2+7*3+9*4 = 70.
        write_th(50);
        out_ready = 1'b0;
        send_vector('{3, 5, 7, 9}, N - 1, -1, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_rise", int'(out_valid), 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_sum", int'(out_sum), 70);
            check("bp_hold_fire", int'(out_fire), 1);
            check("bp_in_ready_low", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_after", int'(in_ready), 1);
        check("bp_out_valid_after", int'(out_valid), 0);
        check("bp_consumed", exp_q.size(), 0);
        send_vector('{2, 0, 0, 1}, N - 1, -1, 0);
        drain("bp_next");

        // Same-cycle write to the address being accepted uses the old weight.
        send_vector('{1, 1, 1, 1}, N - 1, 2, 9);
        drain("wr_same_addr");
        send_vector('{1, 1, 1, 1}, N - 1, -1, 0);
        drain("wr_same_addr_after");

        send_vector('{1, 2, 3, 4}, 1, -1, 0);
        drain("early_last");

        // Reset in the WAIT phase of element 2.
        send_elem(1, 1'b0, 1'b0, 0, 0);
        send_elem(2, 1'b0, 1'b0, 0, 0);
        send_elem(3, 1'b0, 1'b0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_wait_rst");
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) write_w(i, i + 2);
        write_th(40);
        send_vector('{4, 3, 2, 1}, N - 1, -1, 0);
        drain("after_rst");

        rnd_bp = 1'b1;
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < N; i++) write_w(i, int'($urandom_range(0, 15)));
            write_th(int'($urandom_range(0, 255)));
            for (int i = 0; i < N; i++) xs[i] = int'($urandom_range(0, 15));
            send_vector(xs, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : N - 1, -1, 0);
            drain("random");
        end
        rnd_bp = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
